game_sequencer: RTL and testbench

//  Central game controller. Broadcasts the 3-bit per-row state code consumed by every row block, and reacts to the
//  OR-reduced Stop/endgame replies. Paces gravity with a fall timer and converts keyboard codes into single-cycle

---
 rtl/tetris_pkg.sv | 50 +++++
 rtl/game_sequencer_if.sv | 22 ++
 rtl/game_sequencer_key_oneshot.sv | 38 +++
 rtl/game_sequencer.sv | 97 +++++++++
 tb/tb_game_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Row-command codes, keyboard codes and sequencer state encoding
// shared by the game sequencer and the row blocks.
package tetris_pkg;

    localparam logic [2:0] CODE_CHECK   = 3'b000;
    localparam logic [2:0] CODE_MOVE    = 3'b001;
    localparam logic [2:0] CODE_WRITE   = 3'b010;
    localparam logic [2:0] CODE_SHIFT   = 3'b011;
    localparam logic [2:0] CODE_ADD     = 3'b100;
    localparam logic [2:0] CODE_HOLD    = 3'b110;
    localparam logic [2:0] CODE_LATERAL = 3'b111;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_ROT   = 8'h1A;
    localparam logic [7:0] KEY_SOFT  = 8'h16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADD,
        S_SPAWN,
        S_FALL,
        S_DROP,
        S_WRITE,
        S_CHECK,
        S_SHIFT,
        S_SETTLE,
        S_OVER
    } fsm_t;

    function automatic logic [2:0] code_of(input fsm_t s);
        logic [2:0] c;
        c = CODE_HOLD;
        case (s)
            S_ADD:   c = CODE_ADD;
            S_DROP:  c = CODE_MOVE;
            S_WRITE: c = CODE_WRITE;
            S_CHECK: c = CODE_CHECK;
            S_SHIFT: c = CODE_SHIFT;
            default: c = CODE_HOLD;
        endcase
        return c;
    endfunction

    function automatic logic is_move_key(input logic [7:0] k);
        return (k == KEY_LEFT) || (k == KEY_RIGHT) || (k == KEY_ROT);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Broadcast bus between the game sequencer (master) and the row blocks;
// the reply lines are already OR-reduced across all rows.
interface game_sequencer_if #(
    parameter int ROWS = 20
);
    logic [2:0]      state;
    logic [7:0]      key_cmd;
    logic [ROWS-1:0] clear_row;
    logic            stop_any;
    logic            endgame_any;
    logic [ROWS-1:0] row_full;

    modport master (
        output state, key_cmd, clear_row,
        input  stop_any, endgame_any, row_full
    );

    modport slave (
        input  state, key_cmd, clear_row,
        output stop_any, endgame_any, row_full
    );
endinterface

// File: rtl/game_sequencer_key_oneshot.sv
// Turns a held movement key into a single pending command; the pending
// flag survives until consumed or explicitly discarded.
module key_oneshot (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode,
    input  logic       clr,
    input  logic       take,
    output logic       pend,
    output logic [7:0] key
);
    import tetris_pkg::*;

    logic [7:0] last_key;
    logic       hit;

    assign hit = is_move_key(keycode) && (keycode != last_key);

    // A fresh press during consumption re-arms, so back-to-back taps both issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_key <= KEY_NONE;
            pend     <= 1'b0;
            key      <= KEY_NONE;
        end else begin
            last_key <= keycode;
            if (clr) begin
                pend <= 1'b0;
            end else if (hit) begin
                pend <= 1'b1;
                key  <= keycode;
            end else if (take) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Central game controller: broadcasts row commands, paces gravity and
// runs the land / write / line-clear / spawn loop.
module game_sequencer #(
    parameter int ROWS       = 20,
    parameter int FALL_TICKS = 12_500_000,
    parameter int SOFT_TICKS = 1_250_000,
    parameter int CNT_W      = 24,
    parameter int LINES_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         keycode,
    game_sequencer_if.master   bus,
    output logic               game_over,
    output logic [LINES_W-1:0] lines
);
    import tetris_pkg::*;

    fsm_t            fsm;
    fsm_t            fsm_next;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] limit;
    logic            expiry;
    logic            pend;
    logic            issue;
    logic [7:0]      key;
    logic [ROWS-1:0] low_bit;
    logic [2:0]      state_q;
    logic [7:0]      key_cmd_q;
    logic [ROWS-1:0] clear_q;

    assign limit = (keycode == KEY_SOFT) ? CNT_W'(SOFT_TICKS - 1)
                                         : CNT_W'(FALL_TICKS - 1);
    // >= so switching to the shorter limit mid-count still expires at once
    assign expiry  = (fsm == S_FALL) && (fall_cnt >= limit);
    assign low_bit = bus.row_full & (~bus.row_full + ROWS'(1));
    assign issue   = pend && (fsm_next == S_FALL);

    key_oneshot u_keys (
        .clk     (clk),
        .reset   (reset),
        .keycode (keycode),
        .clr     (fsm_next == S_WRITE),
        .take    (issue),
        .pend    (pend),
        .key     (key)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fsm <= S_IDLE;
        else       fsm <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm;
        unique case (fsm)
            S_IDLE:   if (start) fsm_next = S_ADD;
            S_ADD:    fsm_next = S_SPAWN;
            S_SPAWN:  fsm_next = bus.endgame_any ? S_OVER : S_FALL;
            S_FALL:   if (expiry) fsm_next = bus.stop_any ? S_WRITE : S_DROP;
            S_DROP:   fsm_next = S_FALL;
            S_WRITE:  fsm_next = S_CHECK;
            S_CHECK:  fsm_next = (|bus.row_full) ? S_SHIFT : S_ADD;
            S_SHIFT:  fsm_next = S_SETTLE;
            S_SETTLE: fsm_next = S_CHECK;
            S_OVER:   fsm_next = S_OVER;
            default:  fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fall_cnt  <= '0;
            state_q   <= CODE_HOLD;
            key_cmd_q <= KEY_NONE;
            clear_q   <= '0;
            game_over <= 1'b0;
            lines     <= '0;
        end else begin
            fall_cnt  <= (fsm == S_FALL && !expiry) ? fall_cnt + CNT_W'(1) : '0;
            state_q   <= issue ? CODE_LATERAL : code_of(fsm_next);
            key_cmd_q <= issue ? key : KEY_NONE;
            clear_q   <= (fsm_next == S_SHIFT) ? low_bit : '0;
            if (fsm_next == S_OVER) game_over <= 1'b1;
            if (fsm == S_IDLE && start)
                lines <= '0;
            else if (fsm == S_SHIFT && lines != '1)
                lines <= lines + LINES_W'(1);
        end
    end

    assign bus.state     = state_q;
    assign bus.key_cmd   = key_cmd_q;
    assign bus.clear_row = clear_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: cycle vectors through a scoreboard queue
// plus hand-written key and reset sequences.
module tb_game_sequencer;
    import tetris_pkg::*;

    localparam int ROWS = 20;
    localparam int FT   = 8;
    localparam int ST   = 3;
    localparam int LW   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    keycode = 8'h00;
    logic          game_over;
    logic [LW-1:0] lines;

    game_sequencer_if #(.ROWS(ROWS)) bus ();

    game_sequencer #(
        .ROWS(ROWS), .FALL_TICKS(FT), .SOFT_TICKS(ST),
        .CNT_W(24), .LINES_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .keycode(keycode),
        .bus(bus), .game_over(game_over), .lines(lines)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            st;
        logic [7:0]      key;
        logic            stop;
        logic            endg;
        logic [ROWS-1:0] full;
        logic [2:0]      e_state;
        logic [7:0]      e_key;
        logic [ROWS-1:0] e_clr;
        logic            e_over;
        logic [LW-1:0]   e_lines;
    } vec_t;

    typedef struct {
        logic [2:0]      s;
        logic [7:0]      k;
        logic [ROWS-1:0] c;
        logic            o;
        logic [LW-1:0]   l;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int lat, good, bad;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void add(input logic st, input logic [7:0] k,
                                input logic sp, input logic eg,
                                input logic [ROWS-1:0] rf,
                                input logic [2:0] es, input logic [7:0] ek,
                                input logic [ROWS-1:0] ec, input logic eo,
                                input logic [LW-1:0] el);
        tbl.push_back('{st, k, sp, eg, rf, es, ek, ec, eo, el});
    endfunction

    // n quiet cycles expecting the no-op code
    function automatic void holds(input int n, input logic [7:0] k,
                                  input logic [LW-1:0] el);
        for (int i = 0; i < n; i++)
            add(1'b0, k, 1'b0, 1'b0, '0, CODE_HOLD, 8'h00, '0, 1'b0, el);
    endfunction

    task automatic run_tbl(input string tag);
        vec_t v;
        exp_t e;
        int   n;
        n = 0;
        while (tbl.size() > 0) begin
            v = tbl.pop_front();
            start = v.st;
            keycode = v.key;
            bus.stop_any = v.stop;
            bus.endgame_any = v.endg;
            bus.row_full = v.full;
            sb.push_back('{v.e_state, v.e_key, v.e_clr, v.e_over, v.e_lines});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("%s[%0d].state", tag, n), 32'(bus.state), 32'(e.s));
            check($sformatf("%s[%0d].key_cmd", tag, n), 32'(bus.key_cmd), 32'(e.k));
            check($sformatf("%s[%0d].clear_row", tag, n), 32'(bus.clear_row), 32'(e.c));
            check($sformatf("%s[%0d].game_over", tag, n), 32'(game_over), 32'(e.o));
            check($sformatf("%s[%0d].lines", tag, n), 32'(lines), 32'(e.l));
            n++;
        end
        start = 1'b0;
        keycode = 8'h00;
        bus.stop_any = 1'b0;
        bus.endgame_any = 1'b0;
        bus.row_full = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        start = 1'b0;
        keycode = 8'h00;
        bus.stop_any = 1'b0;
        bus.endgame_any = 1'b0;
        bus.row_full = '0;
        @(posedge clk);
        #1;
        check("reset.state", 32'(bus.state), 32'(CODE_HOLD));
        check("reset.key_cmd", 32'(bus.key_cmd), 32'h0);
        check("reset.clear_row", 32'(bus.clear_row), 32'h0);
        check("reset.game_over", 32'(game_over), 32'h0);
        check("reset.lines", 32'(lines), 32'h0);
        reset = 1'b0;
    endtask

    task automatic sync_move(input string tag);
        int n;
        n = 0;
        while (bus.state !== CODE_MOVE && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.state !== CODE_MOVE) begin
            errors++;
            $display("FAIL %s.sync: no MOVE within 40 cycles, got %0b", tag, bus.state);
        end
    endtask

    task automatic press(input logic [7:0] k, input int n,
                         input logic [7:0] want,
                         inout int lat_n, inout int good_n, inout int bad_n);
        keycode = k;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.state == CODE_LATERAL) begin
                lat_n++;
                if (bus.key_cmd == want) good_n++;
            end else if (bus.key_cmd != 8'h00) begin
                bad_n++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // start, spawn, two full gravity periods
        do_reset;
        add(1'b1, 8'h00, 1'b0, 1'b0, '0, CODE_ADD, 8'h00, '0, 1'b0, 16'd0);
        holds(1 + FT, 8'h00, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_MOVE, 8'h00, '0, 1'b0, 16'd0);
        holds(FT, 8'h00, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_MOVE, 8'h00, '0, 1'b0, 16'd0);
        run_tbl("t1");

        // held key issues once; re-press of another key issues once
        lat = 0; good = 0; bad = 0;
        press(KEY_RIGHT, 50, KEY_RIGHT, lat, good, bad);
        press(8'h00, 5, KEY_RIGHT, lat, good, bad);
        check("t3.right_pulses", 32'(lat), 32'd1);
        check("t3.right_key", 32'(good), 32'd1);
        lat = 0; good = 0;
        press(KEY_LEFT, 10, KEY_LEFT, lat, good, bad);
        press(8'h00, 5, KEY_LEFT, lat, good, bad);
        check("t3.left_pulses", 32'(lat), 32'd1);
        check("t3.left_key", 32'(good), 32'd1);
        check("t3.stray_key_cmd", 32'(bad), 32'd0);

        // key edge on expiry cycle, no landing: MOVE then LATERAL
        sync_move("t4a");
        holds(FT, 8'h00, 16'd0);
        add(1'b0, KEY_RIGHT, 1'b0, 1'b0, '0, CODE_MOVE, 8'h00, '0, 1'b0, 16'd0);
        add(1'b0, KEY_RIGHT, 1'b0, 1'b0, '0, CODE_LATERAL, KEY_RIGHT, '0, 1'b0, 16'd0);
        holds(2, KEY_RIGHT, 16'd0);
        run_tbl("t4a");

        // key edge on landing expiry is discarded; two rows cleared
        sync_move("t5");
        holds(FT, 8'h00, 16'd0);
        add(1'b0, KEY_LEFT, 1'b1, 1'b0, '0, CODE_WRITE, 8'h00, '0, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_CHECK, 8'h00, '0, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 20'h5, CODE_SHIFT, 8'h00, 20'h1, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 20'h1, CODE_HOLD, 8'h00, '0, 1'b0, 16'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 20'h1, CODE_CHECK, 8'h00, '0, 1'b0, 16'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 20'h1, CODE_SHIFT, 8'h00, 20'h1, 1'b0, 16'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_HOLD, 8'h00, '0, 1'b0, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_CHECK, 8'h00, '0, 1'b0, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_ADD, 8'h00, '0, 1'b0, 16'd2);
        holds(1 + FT, 8'h00, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_MOVE, 8'h00, '0, 1'b0, 16'd2);
        run_tbl("t5");

        // spawn collision ends the game; everything else ignored
        do_reset;
        add(1'b1, 8'h00, 1'b0, 1'b0, '0, CODE_ADD, 8'h00, '0, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_HOLD, 8'h00, '0, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, '0, CODE_HOLD, 8'h00, '0, 1'b1, 16'd0);
        for (int i = 0; i < 12; i++)
            add(1'b1, (i % 2 == 0) ? KEY_RIGHT : KEY_LEFT, 1'b1, 1'b0,
                20'h3, CODE_HOLD, 8'h00, '0, 1'b1, 16'd0);
        run_tbl("t2");

        // reset in the middle of a second SHIFT
        do_reset;
        add(1'b1, 8'h00, 1'b0, 1'b0, '0, CODE_ADD, 8'h00, '0, 1'b0, 16'd0);
        holds(1 + FT, 8'h00, 16'd0);
        add(1'b0, 8'h00, 1'b1, 1'b0, '0, CODE_WRITE, 8'h00, '0, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_CHECK, 8'h00, '0, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 20'h3, CODE_SHIFT, 8'h00, 20'h1, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 20'h2, CODE_HOLD, 8'h00, '0, 1'b0, 16'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 20'h2, CODE_CHECK, 8'h00, '0, 1'b0, 16'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 20'h2, CODE_SHIFT, 8'h00, 20'h2, 1'b0, 16'd1);
        run_tbl("t6a");
        #2;
        reset = 1'b1;
        #1;
        check("t6.rst_state", 32'(bus.state), 32'(CODE_HOLD));
        check("t6.rst_clear_row", 32'(bus.clear_row), 32'h0);
        check("t6.rst_lines", 32'(lines), 32'h0);
        check("t6.rst_key_cmd", 32'(bus.key_cmd), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // soft drop shortens the period, release restores it
        add(1'b1, KEY_SOFT, 1'b0, 1'b0, '0, CODE_ADD, 8'h00, '0, 1'b0, 16'd0);
        holds(1 + ST, KEY_SOFT, 16'd0);
        add(1'b0, KEY_SOFT, 1'b0, 1'b0, '0, CODE_MOVE, 8'h00, '0, 1'b0, 16'd0);
        holds(ST, KEY_SOFT, 16'd0);
        add(1'b0, KEY_SOFT, 1'b0, 1'b0, '0, CODE_MOVE, 8'h00, '0, 1'b0, 16'd0);
        holds(FT, 8'h00, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, '0, CODE_MOVE, 8'h00, '0, 1'b0, 16'd0);
        run_tbl("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
